// File: rtl/pulse_rx.sv
// pulse_rx
//   Receiver/decoder for pulse-coded lines. It samples one asynchronous line,
//   opens a frame on the first departure from the idle level, counts the
//   completed non-idle pulses, measures the last non-idle pulse and the last
//   in-frame idle gap, and closes the frame after TIMEOUT consecutive idle
//   cycles.
//
// Ports
//   clock        in   1          clock
//   reset        in   1          asynchronous, active-low
//   enable       in   1          0 = abort / hold in IDLE
//   sig_i        in   1          asynchronous pulse line
//   busy         out  1          frame in progress
//   done         out  1          one-cycle strobe at frame end
//   pulse_count  out  CNT_WIDTH  completed non-idle pulses in the frame
//   act_width    out  WIDTH      last non-idle pulse length, cycles-1
//   gap_width    out  WIDTH      last in-frame idle gap length, cycles-1
//   overflow     out  1          sticky per frame: a width or the count saturated
module pulse_rx #(
  parameter int   WIDTH      = 4,
  parameter int   CNT_WIDTH  = 8,
  parameter int   TIMEOUT    = 20,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_i,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulse_count,
  output logic [WIDTH-1:0]     act_width,
  output logic [WIDTH-1:0]     gap_width,
  output logic                 overflow
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0]     RUN_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [IW-1:0]        IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Synchronizer and one-cycle delay. All preset to the idle level so that
  // leaving reset never manufactures an edge.
  logic sync_a_reg;
  logic s_reg;
  logic s_d_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a_reg <= IDLE_LEVEL;
      s_reg      <= IDLE_LEVEL;
      s_d_reg    <= IDLE_LEVEL;
    end else begin
      sync_a_reg <= sig_i;
      s_reg      <= sync_a_reg;
      s_d_reg    <= s_reg;
    end
  end

  logic line_edge;
  logic at_idle;
  assign line_edge = s_reg ^ s_d_reg;
  assign at_idle   = (s_reg == IDLE_LEVEL);

  state_t                 state_reg,   state_next;
  logic [WIDTH-1:0]       run_cnt_reg, run_cnt_next;
  logic                   run_sat_reg, run_sat_next;
  logic [IW-1:0]          idle_cnt_reg, idle_cnt_next;
  logic                   busy_reg,    busy_next;
  logic                   done_reg,    done_next;
  logic [CNT_WIDTH-1:0]   count_reg,   count_next;
  logic [WIDTH-1:0]       act_reg,     act_next;
  logic [WIDTH-1:0]       gap_reg,     gap_next;
  logic                   ovf_reg,     ovf_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      run_cnt_reg  <= '0;
      run_sat_reg  <= 1'b0;
      idle_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      count_reg    <= '0;
      act_reg      <= '0;
      gap_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      run_sat_reg  <= run_sat_next;
      idle_cnt_reg <= idle_cnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      count_reg    <= count_next;
      act_reg      <= act_next;
      gap_reg      <= gap_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    run_cnt_next  = run_cnt_reg;
    run_sat_next  = run_sat_reg;
    idle_cnt_next = idle_cnt_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    count_next    = count_reg;
    act_next      = act_reg;
    gap_next      = gap_reg;
    ovf_next      = ovf_reg;

    // Level-hold counter: value seen at the closing edge is hold cycles - 1.
    // run_sat remembers that the current level outlasted the counter range,
    // so a long gap can be flagged when it is eventually stored.
    if (line_edge) begin
      run_cnt_next = '0;
      run_sat_next = 1'b0;
    end else if (run_cnt_reg != RUN_MAX) begin
      run_cnt_next = run_cnt_reg + WIDTH'(1);
    end else begin
      run_sat_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        idle_cnt_next = '0;
        if (enable && line_edge && !at_idle) begin
          state_next = ST_RUN;
          busy_next  = 1'b1;
          count_next = '0;
          act_next   = '0;
          gap_next   = '0;
          ovf_next   = 1'b0;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_next    = ST_IDLE;
          busy_next     = 1'b0;
          idle_cnt_next = '0;
        end else begin
          if (line_edge && at_idle) begin
            act_next = run_cnt_reg;
            if (count_reg == CNT_MAX) ovf_next = 1'b1;
            else                      count_next = count_reg + CNT_WIDTH'(1);
          end
          if (line_edge && !at_idle) begin
            gap_next = run_cnt_reg;
            if (run_sat_reg) ovf_next = 1'b1;
          end
          // Active-level saturation is flagged live so a stuck line shows
          // overflow while the frame is still open. Idle saturation is only
          // flagged if that gap gets stored, which keeps the trailing
          // timeout gap from polluting overflow.
          if (!line_edge && !at_idle && run_cnt_reg == RUN_MAX) ovf_next = 1'b1;

          if (at_idle) begin
            if (idle_cnt_reg == IDLE_LAST) begin
              done_next     = 1'b1;
              busy_next     = 1'b0;
              state_next    = ST_IDLE;
              idle_cnt_next = '0;
            end else begin
              idle_cnt_next = idle_cnt_reg + IW'(1);
            end
          end else begin
            idle_cnt_next = '0;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign pulse_count = count_reg;
  assign act_width   = act_reg;
  assign gap_width   = gap_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_pulse_rx.sv
// tb_pulse_rx
//   Randomized and directed frames for pulse_rx. Each frame is described as a
//   list of low (non-idle) hold lengths and the idle gaps between them; the
//   expected frame results are computed from those lengths and queued, and a
//   monitor compares them whenever the DUT strobes done.
module tb_pulse_rx;

  localparam int WIDTH     = 4;
  localparam int CNT_WIDTH = 8;
  localparam int TIMEOUT   = 20;
  localparam int RUN_SAT   = (1 << WIDTH) - 1;
  localparam int CNT_SAT   = (1 << CNT_WIDTH) - 1;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic                 sig_i;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] pulse_count;
  logic [WIDTH-1:0]     act_width;
  logic [WIDTH-1:0]     gap_width;
  logic                 overflow;

  pulse_rx #(
    .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT), .IDLE_LEVEL(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sig_i(sig_i),
    .busy(busy), .done(done), .pulse_count(pulse_count),
    .act_width(act_width), .gap_width(gap_width), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int     cnt;
    int     act;
    int     gap;
    int     ovf;
    longint done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   seg_low[$];
  int   seg_high[$];

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Scoreboard monitor: one line per completed frame.
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check("done_without_frame", done, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("frame done @%0d: count=%0d act=%0d gap=%0d ovf=%0d (want %0d/%0d/%0d/%0d)",
                 cyc, pulse_count, act_width, gap_width, overflow, e.cnt, e.act, e.gap, e.ovf);
        check("pulse_count", pulse_count, e.cnt);
        check("act_width",   act_width,   e.act);
        check("gap_width",   gap_width,   e.gap);
        check("overflow",    overflow,    e.ovf);
        check("done_time",   cyc,         e.done_cyc);
        check("busy_at_done", busy,       0);
      end
    end
  end

  // Drives seg_low/seg_high as one frame and queues its expected results.
  // Called and returns on a falling clock edge; returns 3 cycles after the
  // final return to idle, still inside the frame.
  task automatic run_frame();
    exp_t e;
    int   n;
    n     = seg_low.size();
    e.cnt = (n > CNT_SAT) ? CNT_SAT : n;
    e.act = (seg_low[n-1] - 1 > RUN_SAT) ? RUN_SAT : seg_low[n-1] - 1;
    e.gap = 0;
    if (n > 1) e.gap = (seg_high[n-2] - 1 > RUN_SAT) ? RUN_SAT : seg_high[n-2] - 1;
    e.ovf = (n > CNT_SAT) ? 1 : 0;
    foreach (seg_low[i])  if (seg_low[i] > RUN_SAT + 1) e.ovf = 1;
    for (int i = 0; i < n - 1; i++) if (seg_high[i] > RUN_SAT + 1) e.ovf = 1;
    for (int i = 0; i < n; i++) begin
      sig_i = 1'b0;
      repeat (seg_low[i]) @(negedge clock);
      sig_i = 1'b1;
      if (i == n - 1) begin
        e.done_cyc = cyc + TIMEOUT + 2;
        exp_q.push_back(e);
      end else begin
        repeat (seg_high[i]) @(negedge clock);
      end
    end
    repeat (3) @(negedge clock);
    check("busy_in_frame", busy, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int busy_seen;
    reset  = 1'b0;
    enable = 1'b1;
    sig_i  = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_count", pulse_count, 0);
    check("rst_ovf",   overflow, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // 1: reset in the middle of a frame
    sig_i = 1'b0; repeat (3) @(negedge clock);
    sig_i = 1'b1; repeat (3) @(negedge clock);
    sig_i = 1'b0; repeat (4) @(negedge clock);
    check("t1_busy_before_reset",  busy, 1);
    check("t1_count_before_reset", pulse_count, 1);
    #2 reset = 1'b0;
    #1;
    check("t1_busy",  busy, 0);
    check("t1_done",  done, 0);
    check("t1_count", pulse_count, 0);
    check("t1_act",   act_width, 0);
    check("t1_gap",   gap_width, 0);
    check("t1_ovf",   overflow, 0);
    sig_i = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (busy) busy_seen++;
    end
    check("t1_idle_line_busy", busy_seen, 0);

    // 2: two pulses, expect count 2, act 3, gap 2
    seg_low = '{4, 4}; seg_high = '{3};
    run_frame(); wait_drain();

    // 3: stuck low for 40 cycles
    seg_low = '{40}; seg_high = '{};
    run_frame(); wait_drain();

    // 4: abort with enable low
    sig_i = 1'b0; repeat (4) @(negedge clock);
    sig_i = 1'b1; repeat (3) @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    check("t4_busy",  busy, 0);
    check("t4_count", pulse_count, 1);
    repeat (30) @(negedge clock);
    enable = 1'b1;
    repeat (3) @(negedge clock);
    seg_low = '{2}; seg_high = '{};
    run_frame(); wait_drain();

    // 5: generator loopback shape: 4 lows of 3 cycles, highs of 6
    seg_low = '{3, 3, 3, 3}; seg_high = '{6, 6, 6};
    run_frame(); wait_drain();

    // 6: two frames 25 idle cycles apart
    seg_low = '{5, 2}; seg_high = '{7};
    run_frame();
    repeat (22) @(negedge clock);
    check("t6_busy_between", busy, 0);
    seg_low = '{9, 3, 6}; seg_high = '{2, 18};
    run_frame(); wait_drain();

    // Randomized frames, including long lows and long in-frame gaps
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 5);
      seg_low.delete(); seg_high.delete();
      for (int i = 0; i < n; i++) begin
        seg_low.push_back($urandom_range(1, 20));
        if (i < n - 1) seg_high.push_back($urandom_range(1, TIMEOUT - 1));
      end
      run_frame(); wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
